// File: rtl/cache_nway_if.sv
// Access bus between the cache-control FSM and cache_nway.
// Optional CACHE_NWAY_STATS_EN adds the hit/miss counter outputs.
interface cache_nway_if #(
  parameter int WAYS     = 4,
  parameter int TAG_W    = 5,
  parameter int INDEX_W  = 8,
  parameter int OFFSET_W = 3,
  parameter int DATA_W   = 16
);
  localparam int WW = $clog2(WAYS);

  logic                enable;
  logic                comp;
  logic                write;
  logic                valid_in;
  logic [TAG_W-1:0]    tag_in;
  logic [INDEX_W-1:0]  index;
  logic [OFFSET_W-1:0] offset;
  logic [DATA_W-1:0]   data_in;

  logic [TAG_W-1:0]    tag_out;
  logic [DATA_W-1:0]   data_out;
  logic                hit;
  logic                dirty;
  logic                valid;
  logic [WW-1:0]       way_out;
  logic                err;
`ifdef CACHE_NWAY_STATS_EN
  logic [15:0]         hit_count;
  logic [15:0]         miss_count;
`endif

  modport master (
    output enable, comp, write, valid_in, tag_in, index, offset, data_in,
    input  tag_out, data_out, hit, dirty, valid, way_out, err
`ifdef CACHE_NWAY_STATS_EN
    , input hit_count, miss_count
`endif
  );

  modport slave (
    input  enable, comp, write, valid_in, tag_in, index, offset, data_in,
    output tag_out, data_out, hit, dirty, valid, way_out, err
`ifdef CACHE_NWAY_STATS_EN
    , output hit_count, miss_count
`endif
  );
endinterface

// File: rtl/cache_nway.sv
// N-way set-associative cache array: per-set round-robin replacement, first-invalid fill, multi-hit err.
// Combinational reads, writes on the rising edge; CACHE_NWAY_STATS_EN adds saturating hit/miss counters.
module cache_nway #(
  parameter int WAYS     = 4,
  parameter int TAG_W    = 5,
  parameter int INDEX_W  = 8,
  parameter int OFFSET_W = 3,
  parameter int DATA_W   = 16
) (
  input logic        clk,
  input logic        rst,
  cache_nway_if.slave bus
);
  localparam int WW    = $clog2(WAYS);
  localparam int SETS  = 1 << INDEX_W;
  localparam int WORDS = 1 << (OFFSET_W - 1);

  logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
  logic [DATA_W-1:0] data_mem [WAYS][SETS][WORDS];
  logic [SETS-1:0]   valid_q  [WAYS];
  logic [SETS-1:0]   dirty_q  [WAYS];
  logic [WW-1:0]     rr_q     [SETS];
  logic [WW-1:0]     alloc_q;

  logic [OFFSET_W-2:0] word;
  logic [WAYS-1:0]     hit_vec;
  logic [WAYS-1:0]     inv_vec;
  logic [WW-1:0]       hit_way;
  logic [WW-1:0]       inv_way;
  logic [WW-1:0]       victim;
  logic [WW-1:0]       sel;
  logic                any_hit;
  logic                set_full;
  logic                multi_hit;

  assign word = bus.offset[OFFSET_W-1:1];

  always_comb begin
    hit_vec = '0;
    inv_vec = '0;
    hit_way = '0;
    inv_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_q[w][bus.index] && (tag_mem[w][bus.index] == bus.tag_in);
      inv_vec[w] = !valid_q[w][bus.index];
    end
    // Descending scan so the lowest-numbered way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = WW'(w);
      if (inv_vec[w]) inv_way = WW'(w);
    end
  end

  assign any_hit   = |hit_vec;
  assign set_full  = ~|inv_vec;
  assign multi_hit = (hit_vec & (hit_vec - WAYS'(1))) != '0;
  assign victim    = set_full ? rr_q[bus.index] : inv_way;
  assign sel       = bus.comp ? (any_hit ? hit_way : victim) : alloc_q;

  always_comb begin
    bus.tag_out  = '0;
    bus.data_out = '0;
    bus.hit      = 1'b0;
    bus.dirty    = 1'b0;
    bus.valid    = 1'b0;
    bus.way_out  = '0;
    bus.err      = 1'b0;
    if (bus.enable) begin
      bus.tag_out  = tag_mem[sel][bus.index];
      bus.data_out = data_mem[sel][bus.index][word];
      bus.hit      = bus.comp && any_hit;
      bus.dirty    = dirty_q[sel][bus.index];
      bus.valid    = valid_q[sel][bus.index];
      bus.way_out  = sel;
      bus.err      = bus.comp && multi_hit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
      alloc_q <= '0;
    end else if (bus.enable) begin
      if (bus.comp) begin
        if (any_hit) begin
          if (bus.write) dirty_q[hit_way][bus.index] <= 1'b1;
        end else begin
          alloc_q <= victim;
        end
      end else if (bus.write) begin
        valid_q[alloc_q][bus.index] <= bus.valid_in;
        dirty_q[alloc_q][bus.index] <= 1'b0;
        // Pointer only moves when the fill actually replaces the round-robin victim.
        if (set_full && (alloc_q == rr_q[bus.index]))
          rr_q[bus.index] <= rr_q[bus.index] + 1'b1;
      end
    end
  end

  // Tag/data arrays carry no reset; a reset held at the edge still blocks the write.
  always_ff @(posedge clk) begin
    if (!rst && bus.enable && bus.write) begin
      if (bus.comp) begin
        if (any_hit) data_mem[hit_way][bus.index][word] <= bus.data_in;
      end else begin
        data_mem[alloc_q][bus.index][word] <= bus.data_in;
        tag_mem[alloc_q][bus.index]        <= bus.tag_in;
      end
    end
  end

`ifdef CACHE_NWAY_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.hit_count  <= '0;
      bus.miss_count <= '0;
    end else if (bus.enable && bus.comp) begin
      if (any_hit) begin
        if (bus.hit_count != 16'hFFFF) bus.hit_count <= bus.hit_count + 16'd1;
      end else begin
        if (bus.miss_count != 16'hFFFF) bus.miss_count <= bus.miss_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_nway.sv
// Scoreboard bench for cache_nway: directed sequence then random traffic against an array-level model.
// Stimulus pushes expected outputs; a negedge monitor pops and compares.
module tb_cache_nway;
  localparam int WAYS = 4, TAG_W = 5, INDEX_W = 8, OFFSET_W = 3, DATA_W = 16;
  localparam int WW = $clog2(WAYS);
  localparam int SETS = 1 << INDEX_W;
  localparam int WORDS = 1 << (OFFSET_W - 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_nway_if #(.WAYS(WAYS), .TAG_W(TAG_W), .INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W), .DATA_W(DATA_W)) bus ();
  cache_nway #(.WAYS(WAYS), .TAG_W(TAG_W), .INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic hit, err, valid, dirty;
    logic [WW-1:0] way;
    logic [TAG_W-1:0] tag;
    logic [DATA_W-1:0] data;
    bit tag_known, data_known;
    int lit_way, lit_tag, lit_data, lit_dirty, lit_valid, lit_hit, lit_err;
    int hc, mc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference state: plain arrays, ways listed per set.
  int  m_tag  [WAYS][SETS];
  bit  m_tk   [WAYS][SETS];
  int  m_data [WAYS][SETS][WORDS];
  bit  m_dk   [WAYS][SETS][WORDS];
  bit  m_val  [WAYS][SETS];
  bit  m_dir  [WAYS][SETS];
  int  m_rr   [SETS];
  int  m_alloc, m_hc, m_mc;
  int  lit_way = -1, lit_tag = -1, lit_data = -1, lit_dirty = -1, lit_valid = -1, lit_hit = -1, lit_err = -1;

  task automatic model_reset();
    for (int w = 0; w < WAYS; w++)
      for (int s = 0; s < SETS; s++) begin
        m_val[w][s] = 0;
        m_dir[w][s] = 0;
      end
    for (int s = 0; s < SETS; s++) m_rr[s] = 0;
    m_alloc = 0; m_hc = 0; m_mc = 0;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic cyc(bit r, bit en, bit cp, bit wr, bit vi, int tg, int idx, int off, int dat);
    exp_t e;
    int hits[$];
    int inv, victim, sel, wd;
    bit full;
    rst = r; bus.enable = en; bus.comp = cp; bus.write = wr; bus.valid_in = vi;
    bus.tag_in = TAG_W'(tg); bus.index = INDEX_W'(idx); bus.offset = OFFSET_W'(off); bus.data_in = DATA_W'(dat);
    if (r) model_reset();
    wd = off >> 1;
    inv = -1;
    for (int w = 0; w < WAYS; w++) begin
      if (m_val[w][idx] && m_tk[w][idx] && m_tag[w][idx] == tg) hits.push_back(w);
      if (!m_val[w][idx] && inv < 0) inv = w;
    end
    full = (inv < 0);
    victim = full ? m_rr[idx] : inv;
    sel = !cp ? m_alloc : (hits.size() > 0 ? hits[0] : victim);
    e.hc = m_hc; e.mc = m_mc;
    e.lit_way = lit_way; e.lit_tag = lit_tag; e.lit_data = lit_data; e.lit_dirty = lit_dirty;
    e.lit_valid = lit_valid; e.lit_hit = lit_hit; e.lit_err = lit_err;
    if (!en) begin
      e.hit = 0; e.err = 0; e.valid = 0; e.dirty = 0; e.way = '0; e.tag = '0; e.data = '0;
      e.tag_known = 1; e.data_known = 1;
    end else begin
      e.hit = cp && hits.size() > 0;
      e.err = cp && hits.size() > 1;
      e.way = WW'(sel);
      e.valid = m_val[sel][idx];
      e.dirty = m_dir[sel][idx];
      e.tag = TAG_W'(m_tag[sel][idx]);   e.tag_known = m_tk[sel][idx];
      e.data = DATA_W'(m_data[sel][idx][wd]); e.data_known = m_dk[sel][idx][wd];
    end
    exp_q.push_back(e);
    lit_way = -1; lit_tag = -1; lit_data = -1; lit_dirty = -1; lit_valid = -1; lit_hit = -1; lit_err = -1;
    @(posedge clk);
    if (!r && en) begin
      if (cp) begin
        if (hits.size() > 0) begin
          if (m_hc < 65535) m_hc++;
          if (wr) begin
            m_data[hits[0]][idx][wd] = dat & 16'hFFFF; m_dk[hits[0]][idx][wd] = 1;
            m_dir[hits[0]][idx] = 1;
          end
        end else begin
          if (m_mc < 65535) m_mc++;
          m_alloc = victim;
        end
      end else if (wr) begin
        if (full && m_alloc == m_rr[idx]) m_rr[idx] = (m_rr[idx] + 1) % WAYS;
        m_data[m_alloc][idx][wd] = dat & 16'hFFFF; m_dk[m_alloc][idx][wd] = 1;
        m_tag[m_alloc][idx] = tg; m_tk[m_alloc][idx] = 1;
        m_val[m_alloc][idx] = vi; m_dir[m_alloc][idx] = 0;
      end
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("hit", 32'(bus.hit), 32'(e.hit));
      chk("err", 32'(bus.err), 32'(e.err));
      chk("valid", 32'(bus.valid), 32'(e.valid));
      chk("dirty", 32'(bus.dirty), 32'(e.dirty));
      chk("way_out", 32'(bus.way_out), 32'(e.way));
      if (e.tag_known)  chk("tag_out", 32'(bus.tag_out), 32'(e.tag));
      if (e.data_known) chk("data_out", 32'(bus.data_out), 32'(e.data));
      if (e.lit_way >= 0)   chk("plan_way", 32'(bus.way_out), e.lit_way);
      if (e.lit_tag >= 0)   chk("plan_tag", 32'(bus.tag_out), e.lit_tag);
      if (e.lit_data >= 0)  chk("plan_data", 32'(bus.data_out), e.lit_data);
      if (e.lit_dirty >= 0) chk("plan_dirty", 32'(bus.dirty), e.lit_dirty);
      if (e.lit_valid >= 0) chk("plan_valid", 32'(bus.valid), e.lit_valid);
      if (e.lit_hit >= 0)   chk("plan_hit", 32'(bus.hit), e.lit_hit);
      if (e.lit_err >= 0)   chk("plan_err", 32'(bus.err), e.lit_err);
`ifdef CACHE_NWAY_STATS_EN
      chk("hit_count", 32'(bus.hit_count), e.hc);
      chk("miss_count", 32'(bus.miss_count), e.mc);
`endif
    end
  end

  initial begin
    for (int w = 0; w < WAYS; w++)
      for (int s = 0; s < SETS; s++) begin
        m_tk[w][s] = 0;
        for (int k = 0; k < WORDS; k++) m_dk[w][s][k] = 0;
      end
    model_reset();
    bus.enable = 0; bus.comp = 0; bus.write = 0; bus.valid_in = 0;
    bus.tag_in = '0; bus.index = '0; bus.offset = '0; bus.data_in = '0;
    @(posedge clk); #1;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    lit_hit = 0; lit_valid = 0; lit_way = 0; lit_err = 0;
    cyc(0, 1, 1, 0, 0, 'hA, 3, 0, 0);
    for (int t = 1; t <= 4; t++) begin
      lit_way = t - 1; lit_hit = 0;
      cyc(0, 1, 1, 0, 0, t, 3, 0, 0);
      cyc(0, 1, 0, 1, 1, t, 3, 0, t * 16);
    end
    for (int t = 1; t <= 4; t++) begin
      lit_way = t - 1; lit_hit = 1; lit_data = t * 16;
      cyc(0, 1, 1, 0, 0, t, 3, 0, 0);
    end
    lit_way = 0; lit_valid = 1; lit_tag = 1; lit_hit = 0;
    cyc(0, 1, 1, 0, 0, 5, 3, 0, 0);
    cyc(0, 1, 0, 1, 1, 5, 3, 0, 'h55);
    lit_hit = 1; lit_way = 1;
    cyc(0, 1, 1, 1, 0, 2, 3, 4, 'hBEEF);
    lit_hit = 1; lit_data = 'hBEEF; lit_dirty = 1;
    cyc(0, 1, 1, 0, 0, 2, 3, 4, 0);
    lit_way = 1; lit_dirty = 1; lit_tag = 2; lit_hit = 0;
    cyc(0, 1, 1, 0, 0, 6, 3, 0, 0);
    cyc(0, 1, 1, 0, 0, 7, 'h10, 0, 0);
    cyc(0, 1, 0, 1, 1, 7, 'h10, 0, 'h70);
    cyc(0, 1, 1, 0, 0, 8, 'h10, 0, 0);
    cyc(0, 1, 0, 1, 1, 9, 'h10, 0, 'h90);
    lit_way = 2;
    cyc(0, 1, 1, 0, 0, 8, 'h10, 0, 0);
    cyc(0, 1, 0, 1, 1, 7, 'h10, 0, 'h72);
    lit_hit = 1; lit_err = 1; lit_way = 0; lit_data = 'h70;
    cyc(0, 1, 1, 0, 0, 7, 'h10, 0, 0);
    cyc(0, 0, 1, 1, 1, 7, 'h10, 0, 0);
    // Reset landing on a pending direct write: line must stay invalid.
    cyc(1, 1, 0, 1, 1, 3, 3, 0, 'h1234);
    lit_hit = 0; lit_valid = 0; lit_way = 0;
    cyc(0, 1, 1, 0, 0, 3, 3, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 9) < 6,
          $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, int'($urandom_range(0, 7)),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)));
    end
    bus.enable = 0;
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
